// File: rtl/stcam_pkg.sv
// Shared STCAM sizing and resolver state.
// Imported by the row array, write controller and match resolver.
package stcam_pkg;

  localparam int STCAM_ROWS   = 16;
  localparam int STCAM_ADDR_W = $clog2(STCAM_ROWS);
  localparam int STCAM_CNT_W  = STCAM_ADDR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rsv_state_t;

endpackage

// File: rtl/stcam_prio_enc.sv
// Lowest-set-bit priority encoder for CAM match vectors.
// Also flags an empty vector and a single-bit vector.
module stcam_prio_enc #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]   vec,
  output logic [ADDR_W-1:0] idx,
  output logic              any,
  output logic              single
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - ROWS'(1))) == '0);

endmodule

// File: rtl/stcam_match_resolver.sv
// Turns one captured match vector into an ascending stream of row addresses.
// A search with no hit yields a single miss beat.
module stcam_match_resolver
  import stcam_pkg::*;
#(
  parameter int ROWS   = STCAM_ROWS,
  parameter int ADDR_W = $clog2(ROWS),
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROWS-1:0]   in_match,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  function automatic logic [CNT_W-1:0] popcnt(input logic [ROWS-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < ROWS; i++) s = s + CNT_W'(v[i]);
    return s;
  endfunction

  rsv_state_t        state;
  logic [ROWS-1:0]   pending;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] low_idx;
  logic              any_set;
  logic              one_set;

  stcam_prio_enc #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_enc (
    .vec    (pending),
    .idx    (low_idx),
    .any    (any_set),
    .single (one_set)
  );

  assign busy      = (state == EMIT);
  assign in_ready  = (state == IDLE);
  assign out_valid = busy;
  assign out_hit   = busy && any_set;
  assign out_addr  = busy ? low_idx : '0;
  assign out_last  = busy && (one_set || !any_set);
  assign out_count = count;

  // Capture a vector in IDLE, then retire its lowest set bit per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pending <= in_match;
            count   <= popcnt(in_match);
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              pending <= '0;
              state   <= IDLE;
            end else begin
              pending <= pending & (pending - ROWS'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stcam_match_resolver.sv
// Randomized self-checking bench for stcam_match_resolver.
// Expected beats come from a list of set-bit indices of each vector.
module tb_stcam_match_resolver;

  localparam int ROWS   = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;

  logic              clk = 0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ROWS-1:0]   in_match;
  logic              out_valid;
  logic              out_ready;
  logic              out_hit;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  stcam_match_resolver #(.ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_match  (in_match),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit   (out_hit),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [ROWS-1:0] vec);
    int n;
    n = 0;
    in_valid = 1;
    in_match = vec;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
    in_match = ROWS'($urandom);
  endtask

  // mode 0: always ready, 1: random stalls, 2: 3-cycle stall on first beat
  task automatic drain(input logic [ROWS-1:0] vec, input int mode,
                       input bit offer, input logic [ROWS-1:0] nxt);
    int q[$];
    int nb;
    int stalls;
    bit rdy;
    for (int i = 0; i < ROWS; i++) if (vec[i]) q.push_back(i);
    nb = (q.size() == 0) ? 1 : q.size();
    for (int b = 0; b < nb; b++) begin
      stalls = 0;
      forever begin
        if (mode == 0) rdy = 1;
        else if (mode == 1) rdy = (stalls >= 6) ? 1'b1 : 1'($urandom);
        else rdy = !(b == 0 && stalls < 3);
        out_ready = rdy;
        if (offer) begin
          in_valid = 1;
          in_match = nxt;
        end else begin
          in_match = ROWS'($urandom);
        end
        check("valid", 32'(out_valid), 32'd1);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        check("hit", 32'(out_hit), 32'(q.size() != 0));
        check("addr", 32'(out_addr), (q.size() != 0) ? 32'(q[b]) : 32'd0);
        check("last", 32'(out_last), 32'(b == nb - 1));
        check("count", 32'(out_count), 32'(q.size()));
        tick();
        if (rdy) break;
        stalls++;
      end
    end
    out_ready = 0;
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [ROWS-1:0] v;
    rst = 1;
    in_valid = 0;
    in_match = '0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hit", 32'(out_hit), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);

    accept(16'h0000);
    drain(16'h0000, 0, 0, '0);

    accept(16'h8421);
    drain(16'h8421, 0, 0, '0);

    accept(16'h0006);
    drain(16'h0006, 2, 0, '0);

    accept(16'h8000);
    drain(16'h8000, 1, 0, '0);

    accept(16'hFFFF);
    drain(16'hFFFF, 0, 1, 16'h0003);
    accept(16'h0003);
    drain(16'h0003, 0, 0, '0);

    accept(16'h00F0);
    out_ready = 1;
    check("mid_addr0", 32'(out_addr), 32'd4);
    tick();
    check("mid_addr1", 32'(out_addr), 32'd5);
    tick();
    rst = 1;
    tick();
    rst = 0;
    out_ready = 0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    accept(16'h0001);
    drain(16'h0001, 0, 0, '0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = ROWS'($urandom) & ROWS'($urandom) & ROWS'($urandom);
        2: v = ROWS'(1) << $urandom_range(0, ROWS - 1);
        default: v = ROWS'($urandom);
      endcase
      accept(v);
      drain(v, int'($urandom_range(0, 2)), 1'($urandom), ROWS'($urandom));
      in_valid = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
